// File: rtl/cpu.sv
// Single-cycle 32-bit MIPS-subset core with a STB/WE/ACK data bus.
// Define CPU_DEBUG_NEXT_PC_EN to expose the computed next pc on debug_next_pc.
module cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] Addr,
  input  logic [31:0] Data_I,
  output logic [31:0] Data_O,
  output logic        WE,
  input  logic        ACK,
  output logic        STB,
  output logic [31:0] debug_next_pc
);

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE     = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07, OP_ADDI = 6'h08,
    OP_ADDIU   = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c,
    OP_ORI     = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f, OP_LW   = 6'h23,
    OP_SW      = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
    FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
    FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
    FN_SLT  = 6'h2a, FN_SLTU = 6'h2b
  } funct_e;

  logic [31:0] gpr [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, imm_se, imm_ze, pc_plus4;
  logic [31:0] alu_y, next_pc_calc, pc_next, wr_data;
  logic [4:0]  wr_addr;
  logic        wr_en, is_mem, is_store, is_load, link, stall;

  assign op       = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign shamt    = inst[10:6];
  assign funct    = inst[5:0];
  assign imm_se   = {{16{inst[15]}}, inst[15:0]};
  assign imm_ze   = {16'h0000, inst[15:0]};
  assign pc_plus4 = pc + 32'd4;
  assign rs_val   = (rs == '0) ? '0 : gpr[rs];
  assign rt_val   = (rt == '0) ? '0 : gpr[rt];

  always_comb begin
    alu_y        = rs_val + imm_se;
    wr_en        = 1'b0;
    wr_addr      = rt;
    next_pc_calc = pc_plus4;
    is_mem       = 1'b0;
    is_store     = 1'b0;
    is_load      = 1'b0;
    link         = 1'b0;
    case (op)
      OP_SPECIAL: begin
        wr_addr = rd;
        wr_en   = 1'b1;
        case (funct)
          FN_SLL:  alu_y = rt_val << shamt;
          FN_SRL:  alu_y = rt_val >> shamt;
          FN_SRA:  alu_y = $signed(rt_val) >>> shamt;
          FN_SLLV: alu_y = rt_val << rs_val[4:0];
          FN_SRLV: alu_y = rt_val >> rs_val[4:0];
          FN_SRAV: alu_y = $signed(rt_val) >>> rs_val[4:0];
          FN_JR:   begin wr_en = 1'b0; next_pc_calc = rs_val; end
          FN_JALR: begin link = 1'b1; next_pc_calc = rs_val; end
          FN_ADD, FN_ADDU: alu_y = rs_val + rt_val;
          FN_SUB, FN_SUBU: alu_y = rs_val - rt_val;
          FN_AND:  alu_y = rs_val & rt_val;
          FN_OR:   alu_y = rs_val | rt_val;
          FN_XOR:  alu_y = rs_val ^ rt_val;
          FN_NOR:  alu_y = ~(rs_val | rt_val);
          FN_SLT:  alu_y = {31'b0, ($signed(rs_val) < $signed(rt_val))};
          FN_SLTU: alu_y = {31'b0, (rs_val < rt_val)};
          default: wr_en = 1'b0;
        endcase
      end
      OP_J:     next_pc_calc = {pc_plus4[31:28], inst[25:0], 2'b00};
      OP_JAL: begin
        next_pc_calc = {pc_plus4[31:28], inst[25:0], 2'b00};
        link = 1'b1; wr_en = 1'b1; wr_addr = 5'd31;
      end
      OP_BEQ:   if (rs_val == rt_val) next_pc_calc = pc_plus4 + {imm_se[29:0], 2'b00};
      OP_BNE:   if (rs_val != rt_val) next_pc_calc = pc_plus4 + {imm_se[29:0], 2'b00};
      OP_BLEZ:  if ($signed(rs_val) <= 0) next_pc_calc = pc_plus4 + {imm_se[29:0], 2'b00};
      OP_BGTZ:  if ($signed(rs_val) > 0) next_pc_calc = pc_plus4 + {imm_se[29:0], 2'b00};
      OP_ADDI, OP_ADDIU: wr_en = 1'b1;
      OP_SLTI:  begin wr_en = 1'b1; alu_y = {31'b0, ($signed(rs_val) < $signed(imm_se))}; end
      OP_SLTIU: begin wr_en = 1'b1; alu_y = {31'b0, (rs_val < imm_se)}; end
      OP_ANDI:  begin wr_en = 1'b1; alu_y = rs_val & imm_ze; end
      OP_ORI:   begin wr_en = 1'b1; alu_y = rs_val | imm_ze; end
      OP_XORI:  begin wr_en = 1'b1; alu_y = rs_val ^ imm_ze; end
      OP_LUI:   begin wr_en = 1'b1; alu_y = {inst[15:0], 16'h0000}; end
      OP_LW:    begin wr_en = 1'b1; is_mem = 1'b1; is_load = 1'b1; end
      OP_SW:    begin is_mem = 1'b1; is_store = 1'b1; end
      default:  ;
    endcase
    wr_data = is_load ? Data_I : (link ? pc_plus4 : alu_y);
  end

  // An unacknowledged bus access freezes pc and suppresses the register write.
  assign stall   = is_mem & ~ACK;
  assign pc_next = stall ? pc : next_pc_calc;

  assign STB    = is_mem;
  assign WE     = is_store;
  assign Addr   = alu_y;
  assign Data_O = rt_val;

`ifdef CPU_DEBUG_NEXT_PC_EN
  assign debug_next_pc = pc_next;
`else
  assign debug_next_pc = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) gpr[5'(i)] <= '0;
    end else if (wr_en && !stall && wr_addr != '0) begin
      gpr[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: driver runs a reference ISA model and queues expectations,
// a separate monitor compares DUT outputs each cycle.
module tb_cpu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc, Addr, Data_O, debug_next_pc;
  logic [31:0] inst = '0;
  logic [31:0] Data_I = '0;
  logic        WE, STB;
  logic        ACK = 1'b0;

  cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst), .Addr(Addr),
    .Data_I(Data_I), .Data_O(Data_O), .WE(WE), .ACK(ACK), .STB(STB),
    .debug_next_pc(debug_next_pc)
  );

  always #25 clk = ~clk;

  typedef struct {
    logic [31:0] pc, addr, data_o, nxt;
    logic        stb, we, chk_addr;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] m_pc = '0;
  logic [31:0] m_r [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ISA model: computes expected outputs, then commits the architectural effect.
  task automatic step(input logic [31:0] ins, input logic ack, input logic [31:0] din,
                      input logic rst);
    logic [5:0]  op, fn;
    logic [4:0]  sh, dst;
    logic [31:0] a, b, se, ze, nxt, val, pc4;
    logic        wr, mem, st;
    exp_t        e;
    op  = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
    a   = m_r[ins[25:21]]; b = m_r[ins[20:16]];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0, ins[15:0]};
    pc4 = m_pc + 4;
    nxt = pc4; wr = 1'b0; dst = ins[20:16]; val = '0;
    mem = (op == 6'h23) || (op == 6'h2b);
    st  = (op == 6'h2b);
    case (op)
      6'h00: begin
        dst = ins[15:11]; wr = 1'b1;
        case (fn)
          6'h00: val = b << sh;
          6'h02: val = b >> sh;
          6'h03: val = (b >> sh) | ((b[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
          6'h04: val = b << a[4:0];
          6'h06: val = b >> a[4:0];
          6'h07: val = (b >> a[4:0]) | ((b[31] && a[4:0] != 0) ? ~(32'hFFFF_FFFF >> a[4:0]) : 32'h0);
          6'h08: begin wr = 1'b0; nxt = a; end
          6'h09: begin nxt = a; val = pc4; end
          6'h20, 6'h21: val = a + b;
          6'h22, 6'h23: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h26: val = a ^ b;
          6'h27: val = ~(a | b);
          6'h2a: val = ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
          6'h2b: val = (a < b) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
      end
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin nxt = {pc4[31:28], ins[25:0], 2'b00}; wr = 1'b1; dst = 5'd31; val = pc4; end
      6'h04: if (a == b) nxt = pc4 + se * 4;
      6'h05: if (a != b) nxt = pc4 + se * 4;
      6'h06: if (a[31] || a == 0) nxt = pc4 + se * 4;
      6'h07: if (!a[31] && a != 0) nxt = pc4 + se * 4;
      6'h08, 6'h09: begin wr = 1'b1; val = a + se; end
      6'h0a: begin wr = 1'b1; val = ((a[31] != se[31]) ? a[31] : (a < se)) ? 32'd1 : 32'd0; end
      6'h0b: begin wr = 1'b1; val = (a < se) ? 32'd1 : 32'd0; end
      6'h0c: begin wr = 1'b1; val = a & ze; end
      6'h0d: begin wr = 1'b1; val = a | ze; end
      6'h0e: begin wr = 1'b1; val = a ^ ze; end
      6'h0f: begin wr = 1'b1; val = ins[15:0] * 32'h10000; end
      6'h23: begin wr = 1'b1; val = din; end
      default: ;
    endcase
    e.pc = m_pc; e.stb = mem; e.we = st; e.chk_addr = mem;
    e.addr = a + se; e.data_o = b;
    e.nxt = (mem && !ack) ? m_pc : nxt;
    q.push_back(e);
    if (rst) begin
      m_pc = '0;
      for (int i = 0; i < 32; i++) m_r[i] = '0;
    end else if (!(mem && !ack)) begin
      if (wr && dst != 0) m_r[dst] = val;
      m_pc = nxt;
    end
  endtask

  task automatic issue(input logic [31:0] ins, input int unsigned waits, input logic [31:0] din);
    logic mem;
    mem = (ins[31:26] == 6'h23) || (ins[31:26] == 6'h2b);
    for (int unsigned w = 0; w <= waits; w++) begin
      @(negedge clk);
      reset  = 1'b0;
      inst   = ins;
      ACK    = mem ? ((w == waits) ? 1'b1 : 1'b0) : 1'($urandom_range(0, 1));
      Data_I = (w == waits) ? din : $urandom;
      step(ins, ACK, Data_I, 1'b0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #10;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("STB", {31'b0, STB}, {31'b0, e.stb});
        chk("WE", {31'b0, WE}, {31'b0, e.we});
        chk("Data_O", Data_O, e.data_o);
        if (e.chk_addr) chk("Addr", Addr, e.addr);
`ifdef CPU_DEBUG_NEXT_PC_EN
        chk("debug_next_pc", debug_next_pc, e.nxt);
`else
        chk("debug_next_pc", debug_next_pc, 32'h0);
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation did not complete, got %0d cycles expected fewer", 40000);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [5:0] fn_list [19];
    logic [5:0] op_list [17];
    logic [31:0] ins;
    logic [5:0]  op;
    fn_list = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20, 6'h21,
                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h3f};
    op_list = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a,
                6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3e};
    for (int i = 0; i < 32; i++) m_r[i] = '0;

    reset = 1'b1; inst = '0; ACK = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(32'h0, 1'b0, Data_I, 1'b1);
    repeat (3) issue(32'h0, 0, 32'h0);

    issue(32'h0000_8020, 0, 32'h0);
    issue(32'h3c10_1000, 0, 32'h0);
    issue(32'h2011_1234, 0, 32'h0);
    issue(32'hae11_0000, 2, 32'h0);
    issue(32'h0810_0004, 0, 32'h0);
    issue(32'h8e08_0000, 2, 32'hDEAD_BEEF);
    issue(32'hae08_0004, 0, 32'h0);
    issue(32'h2009_0020, 0, 32'h0);
    issue(32'h0120_0008, 0, 32'h0);
    issue(32'h1000_FFFF, 0, 32'h0);
    issue(32'h1400_FFFF, 0, 32'h0);

    // reset during an unacknowledged load
    @(negedge clk);
    reset = 1'b1; inst = 32'h8e08_0000; ACK = 1'b0;
    step(inst, 1'b0, Data_I, 1'b1);
    issue(32'h0, 0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        ins = {6'h00, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
               5'($urandom_range(0, 15)), 5'($urandom), fn_list[$urandom_range(0, 18)]};
      end else begin
        op  = op_list[$urandom_range(0, 16)];
        ins = {op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom)};
      end
      if (ins[31:26] == 6'h23 || ins[31:26] == 6'h2b)
        issue(ins, $urandom_range(0, 3), $urandom);
      else
        issue(ins, 0, 32'h0);
    end

    repeat (2) @(negedge clk);
    #20;
    chk("queue_drain", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
